// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file.
// Counter sizing and parameter-legality limits.
package regfile_pkg;

    localparam int          CntWidth    = 16;
    localparam logic [15:0] CntSat      = 16'hFFFF;
    localparam int          MaxNumRead  = 8;
    localparam int          MaxNumWrite = 4;

endpackage

// File: rtl/regfile_write_arbiter.sv
// Resolves write ports into per-register enables and data, highest port wins.
// Also flags any same-address collision between enabled ports.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 5,
    parameter int NumWrite  = 2,
    parameter int ZeroReg   = 1,
    localparam int Depth    = 2 ** AddrWidth
) (
    input  logic [NumWrite*AddrWidth-1:0]      WriteRegister_i,
    input  logic [NumWrite*DataWidth-1:0]      WriteData_i,
    input  logic [NumWrite-1:0]                RegWrite_i,
    output logic [Depth-1:0]                   RegWe_o,
    output logic [Depth-1:0][DataWidth-1:0]    RegData_o,
    output logic                               Collision_o
);

    always_comb begin
        RegWe_o   = '0;
        RegData_o = '0;
        // Later ports overwrite earlier ones, so the highest index wins.
        for (int k = 0; k < NumWrite; k++) begin
            logic [AddrWidth-1:0] wa;
            wa = WriteRegister_i[k*AddrWidth +: AddrWidth];
            if (RegWrite_i[k] && !((ZeroReg != 0) && (wa == '0))) begin
                RegWe_o[wa]   = 1'b1;
                RegData_o[wa] = WriteData_i[k*DataWidth +: DataWidth];
            end
        end
    end

    always_comb begin
        Collision_o = 1'b0;
        for (int j = 0; j < NumWrite; j++) begin
            for (int k = j + 1; k < NumWrite; k++) begin
                logic [AddrWidth-1:0] aj;
                logic [AddrWidth-1:0] ak;
                aj = WriteRegister_i[j*AddrWidth +: AddrWidth];
                ak = WriteRegister_i[k*AddrWidth +: AddrWidth];
                if (RegWrite_i[j] && RegWrite_i[k] && (aj == ak)
                    && !((ZeroReg != 0) && (aj == '0))) begin
                    Collision_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multiport_register_file.sv
// N-read / M-write register file with busy scoreboard and collision counter.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 5,
    parameter int NumRead   = 2,
    parameter int NumWrite  = 2,
    parameter int ZeroReg   = 1
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [NumRead*AddrWidth-1:0]  ReadRegister,
    output logic [NumRead*DataWidth-1:0]  ReadData,
    output logic [NumRead-1:0]            ReadBusy,
    input  logic [NumWrite*AddrWidth-1:0] WriteRegister,
    input  logic [NumWrite*DataWidth-1:0] WriteData,
    input  logic [NumWrite-1:0]           RegWrite,
    input  logic                          ReserveEn,
    input  logic [AddrWidth-1:0]          ReserveReg,
    output logic [CntWidth-1:0]           CollisionCount
);

    localparam int Depth = 2 ** AddrWidth;

    if (NumRead < 1 || NumRead > MaxNumRead) begin : g_bad_read
        $error("NumRead out of range");
    end
    if (NumWrite < 1 || NumWrite > MaxNumWrite) begin : g_bad_write
        $error("NumWrite out of range");
    end

    logic [Depth-1:0][DataWidth-1:0] mem_q, mem_d;
    logic [Depth-1:0]                busy_q, busy_d;
    logic [CntWidth-1:0]             cnt_q, cnt_d;

    logic [Depth-1:0]                reg_we;
    logic [Depth-1:0][DataWidth-1:0] reg_wdata;
    logic                            collision;
    logic                            res_ok;

    regfile_write_arbiter #(
        .DataWidth (DataWidth),
        .AddrWidth (AddrWidth),
        .NumWrite  (NumWrite),
        .ZeroReg   (ZeroReg)
    ) u_arb (
        .WriteRegister_i (WriteRegister),
        .WriteData_i     (WriteData),
        .RegWrite_i      (RegWrite),
        .RegWe_o         (reg_we),
        .RegData_o       (reg_wdata),
        .Collision_o     (collision)
    );

    assign res_ok = ReserveEn && !((ZeroReg != 0) && (ReserveReg == '0));

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        for (int r = 0; r < Depth; r++) begin
            if (reg_we[r]) begin
                mem_d[r]  = reg_wdata[r];
                busy_d[r] = 1'b0;
            end
        end
        // Reservation is applied last so it beats a same-cycle write clear.
        if (res_ok) begin
            busy_d[ReserveReg] = 1'b1;
        end
        if (collision && (cnt_q != CntSat)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mem_q  <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        ReadData = '0;
        ReadBusy = '0;
        for (int i = 0; i < NumRead; i++) begin
            logic [AddrWidth-1:0] ra;
            logic [DataWidth-1:0] rd;
            logic                 rb;
            ra = ReadRegister[i*AddrWidth +: AddrWidth];
            rd = mem_q[ra];
            rb = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
            // Arbiter already masks r0 when it is hardwired.
            if (reg_we[ra]) begin
                rd = reg_wdata[ra];
                if (!(res_ok && (ReserveReg == ra))) begin
                    rb = 1'b0;
                end
            end
`endif
            if ((ZeroReg != 0) && (ra == '0)) begin
                rd = '0;
                rb = 1'b0;
            end
            ReadData[i*DataWidth +: DataWidth] = rd;
            ReadBusy[i] = rb;
        end
    end

    assign CollisionCount = cnt_q;

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed table-driven bench for multiport_register_file (default params).
module tb_multiport_register_file;

    logic        Clk;
    logic        Reset;
    logic [9:0]  ReadRegister;
    logic [63:0] ReadData;
    logic [1:0]  ReadBusy;
    logic [9:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [1:0]  RegWrite;
    logic        ReserveEn;
    logic [4:0]  ReserveReg;
    logic [15:0] CollisionCount;

    int nchecks = 0;
    int nerrors = 0;

    multiport_register_file dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .ReadRegister   (ReadRegister),
        .ReadData       (ReadData),
        .ReadBusy       (ReadBusy),
        .WriteRegister  (WriteRegister),
        .WriteData      (WriteData),
        .RegWrite       (RegWrite),
        .ReserveEn      (ReserveEn),
        .ReserveReg     (ReserveReg),
        .CollisionCount (CollisionCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        res;
        logic [4:0]  rr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic [15:0] ec;
    } vec_t;

    vec_t vec [10];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        Reset     = 1'b0;
        RegWrite  = 2'b00;
        ReserveEn = 1'b0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
        idle();
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        ReadRegister = {a1, a0};
        #1;
    endtask

    initial begin
        vec[0] = '{1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0,
                   5'd3, 5'd4, 32'h0, 32'h0, 2'b00, 16'd0};
        vec[1] = '{1'b0, 2'b11, 5'd3, 32'hDEADBEEF, 5'd4, 32'h12345678,
                   1'b0, 5'd0, 5'd3, 5'd4, 32'hDEADBEEF, 32'h12345678,
                   2'b00, 16'd0};
        vec[2] = '{1'b0, 2'b11, 5'd5, 32'hAAAA, 5'd5, 32'h5555, 1'b0, 5'd0,
                   5'd5, 5'd3, 32'h5555, 32'hDEADBEEF, 2'b00, 16'd1};
        vec[3] = '{1'b0, 2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b1, 5'd0,
                   5'd0, 5'd5, 32'h0, 32'h5555, 2'b00, 16'd1};
        vec[4] = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7,
                   5'd7, 5'd0, 32'h0, 32'h0, 2'b01, 16'd1};
        vec[5] = '{1'b0, 2'b01, 5'd7, 32'h77, 5'd0, 32'h0, 1'b1, 5'd7,
                   5'd7, 5'd0, 32'h77, 32'h0, 2'b01, 16'd1};
        vec[6] = '{1'b0, 2'b10, 5'd0, 32'h0, 5'd7, 32'h88, 1'b0, 5'd0,
                   5'd7, 5'd0, 32'h88, 32'h0, 2'b00, 16'd1};
        vec[7] = '{1'b0, 2'b11, 5'd0, 32'h11, 5'd0, 32'h22, 1'b0, 5'd0,
                   5'd0, 5'd7, 32'h0, 32'h88, 2'b00, 16'd1};
        vec[8] = '{1'b0, 2'b11, 5'd10, 32'h1, 5'd11, 32'h2, 1'b0, 5'd0,
                   5'd10, 5'd11, 32'h1, 32'h2, 2'b00, 16'd1};
        vec[9] = '{1'b0, 2'b11, 5'd12, 32'h3, 5'd12, 32'h4, 1'b1, 5'd12,
                   5'd12, 5'd10, 32'h4, 32'h1, 2'b01, 16'd2};

        idle();
        Reset         = 1'b1;
        WriteRegister = '0;
        WriteData     = '0;
        ReserveReg    = '0;
        ReadRegister  = '0;
        step();

        for (int a = 0; a < 32; a += 2) begin
            set_rd(5'(a), 5'(a + 1));
            check($sformatf("rst_rd%0d", a), ReadData[31:0], 32'h0);
            check($sformatf("rst_rd%0d", a + 1), ReadData[63:32], 32'h0);
            check($sformatf("rst_busy%0d", a), {30'd0, ReadBusy}, 32'h0);
        end
        check("rst_cnt", {16'd0, CollisionCount}, 32'h0);

        for (int v = 0; v < 10; v++) begin
            Reset         = vec[v].rst;
            RegWrite      = vec[v].we;
            WriteRegister = {vec[v].wa1, vec[v].wa0};
            WriteData     = {vec[v].wd1, vec[v].wd0};
            ReserveEn     = vec[v].res;
            ReserveReg    = vec[v].rr;
            ReadRegister  = {vec[v].ra1, vec[v].ra0};
            step();
            check($sformatf("v%0d_rd0", v), ReadData[31:0], vec[v].e0);
            check($sformatf("v%0d_rd1", v), ReadData[63:32], vec[v].e1);
            check($sformatf("v%0d_busy", v), {30'd0, ReadBusy},
                  {30'd0, vec[v].eb});
            check($sformatf("v%0d_cnt", v), {16'd0, CollisionCount},
                  {16'd0, vec[v].ec});
        end

        // Same-cycle write/read of r9 with r9 previously reserved.
        ReserveEn  = 1'b1;
        ReserveReg = 5'd9;
        step();
        set_rd(5'd9, 5'd0);
        check("r9_reserved", {31'd0, ReadBusy[0]}, 32'h1);
        WriteRegister = {5'd0, 5'd9};
        WriteData     = {32'h0, 32'hCAFE};
        RegWrite      = 2'b01;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_data", ReadData[31:0], 32'hCAFE);
        check("byp_busy", {31'd0, ReadBusy[0]}, 32'h0);
`else
        check("nobyp_data", ReadData[31:0], 32'h0);
        check("nobyp_busy", {31'd0, ReadBusy[0]}, 32'h1);
`endif
        step();
        check("r9_after", ReadData[31:0], 32'hCAFE);
        check("r9_busy_after", {31'd0, ReadBusy[0]}, 32'h0);

        // Reset beats a concurrent write and reservation.
        Reset         = 1'b1;
        WriteRegister = {5'd0, 5'd9};
        WriteData     = {32'h0, 32'hBEEF};
        RegWrite      = 2'b01;
        ReserveEn     = 1'b1;
        ReserveReg    = 5'd9;
        step();
        set_rd(5'd9, 5'd5);
        check("rst_mid_r9", ReadData[31:0], 32'h0);
        check("rst_mid_r5", ReadData[63:32], 32'h0);
        check("rst_mid_busy", {31'd0, ReadBusy[0]}, 32'h0);
        check("rst_mid_cnt", {16'd0, CollisionCount}, 32'h0);

        // Saturation of the collision counter.
        WriteRegister = {5'd5, 5'd5};
        WriteData     = {32'h5555, 32'hAAAA};
        RegWrite      = 2'b11;
        repeat (16'hFFFE) @(posedge Clk);
        #1;
        check("cnt_fffe", {16'd0, CollisionCount}, 32'hFFFE);
        repeat (2) @(posedge Clk);
        #1;
        check("cnt_sat", {16'd0, CollisionCount}, 32'hFFFF);
        step();
        check("cnt_sat_hold", {16'd0, CollisionCount}, 32'hFFFF);
        set_rd(5'd5, 5'd0);
        check("r5_final", ReadData[31:0], 32'h5555);

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerrors);
        $finish;
    end

endmodule
